// File: rtl/param_dmem_pkg.sv
// param_dmem_pkg
//   Shared definitions for the parameterised data memory: default geometry,
//   the controller state encoding and a helper for sizing the word index.
package param_dmem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 4096;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Width of an index that spans 0..depth-1, never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/param_dmem_array.sv
// param_dmem_array
//   Single-port synchronous word array with per-byte write enables and a
//   registered read port. The storage has no reset; the read register only
//   loads on a read, so its value is held between reads.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable, applies be/wdata at idx
//   re     - read enable, loads rdata from idx
//   idx    - word index (caller guarantees idx < DEPTH when we/re are set)
//   be     - byte enables, bit i covers wdata[8i+7:8i]
//   wdata  - write data
//   rdata  - registered read data
module param_dmem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) begin
        mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/param_dmem.sv
// param_dmem
//   Data memory with a power-up clear sweep. After reset the controller
//   zeroes one word per cycle from address 0 upward, then accepts single
//   word reads (latency 1) and byte-enabled writes. Conflicting or
//   out-of-range requests are rejected with a one-cycle err pulse.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   mem_read   - read request
//   mem_write  - write request
//   addr       - word address
//   din        - write data
//   be         - write byte enables
//   ready      - high once the clear sweep has finished
//   rvalid     - one-cycle pulse marking dout valid
//   dout       - read data, held between reads
//   err        - one-cycle pulse for a rejected request
//
// state    | meaning
// ST_INIT  | clear sweep in progress, requests ignored
// ST_READY | accepting read/write requests
module param_dmem
  import param_dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   dout,
  output logic                err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  // Forces dout to zero: out of reset and after an out-of-range read,
  // without needing a reset on the array's read register.
  logic              zero_q, zero_d;

  logic              in_range;
  logic              rd_req;
  logic              wr_req;

  logic              arr_we;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_idx;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ST_READY;
          clr_cnt_d = '0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d   = ST_INIT;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Output / datapath control
  always_comb begin
    ready     = (state_q == ST_READY);
    in_range  = ({1'b0, addr} < DEPTH_X);
    rd_req    = ready & mem_read;
    wr_req    = ready & mem_write;

    rvalid_d  = rd_req & ~mem_write;
    err_d     = (rd_req & mem_write) | ((rd_req ^ wr_req) & ~in_range);
    zero_d    = zero_q;
    if (rvalid_d) begin
      zero_d = ~in_range;
    end

    if (state_q == ST_INIT) begin
      arr_we    = 1'b1;
      arr_re    = 1'b0;
      arr_idx   = clr_cnt_q;
      arr_be    = '1;
      arr_wdata = '0;
    end else begin
      arr_we    = wr_req & ~mem_read & in_range;
      arr_re    = rd_req & ~mem_write & in_range;
      arr_idx   = addr[IDX_W-1:0];
      arr_be    = be;
      arr_wdata = din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      zero_q   <= zero_d;
    end
  end

  param_dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .be    (arr_be),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign dout   = zero_q ? '0 : arr_rdata;

endmodule
